// File: rtl/gemm_output_drain.sv
// Drain stage: snapshots a row of PE accumulators on capture and streams them out as
// NumLanes-wide beats with valid/ready. Optional DRAIN_SATURATE_EN clamps elements to SatWidth at capture.
module gemm_output_drain #(
  parameter int OutDataWidth = 32,
  parameter int NumPe        = 16,
  parameter int NumLanes     = 4,
  parameter int AddrWidth    = 16,
  parameter int SatWidth     = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumPe*OutDataWidth-1:0]    c_i,
  input  logic                             capture_i,
  output logic                             capture_ready_o,
  input  logic [AddrWidth-1:0]             base_addr_i,
  output logic [NumLanes*OutDataWidth-1:0] out_data_o,
  output logic [AddrWidth-1:0]             out_addr_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic                             out_last_o,
  output logic                             busy_o,
  output logic                             done_o
);

  localparam int Beats = NumPe / NumLanes;
  localparam int BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int BufW  = NumPe * OutDataWidth;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);

  if ((NumPe % NumLanes) != 0) begin : g_bad_lanes
    $error("NumPe must be a multiple of NumLanes");
  end
  if ((SatWidth < 2) || (SatWidth > OutDataWidth)) begin : g_bad_sat
    $error("SatWidth must be in 2..OutDataWidth");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [BeatW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [BufW-1:0]      buf_q, buf_d;
  logic [AddrWidth-1:0] base_q, base_d;
  logic                 done_q, done_d;
  logic [BufW-1:0]      capt_data;

`ifdef DRAIN_SATURATE_EN
  localparam logic [OutDataWidth-1:0] SatMax =
    {{(OutDataWidth-SatWidth+1){1'b0}}, {(SatWidth-1){1'b1}}};
  localparam logic [OutDataWidth-1:0] SatMin = ~SatMax;

  logic [OutDataWidth-1:0] elem;

  // Clamp is folded into the capture path so drain latency is unchanged.
  always_comb begin
    capt_data = '0;
    elem      = '0;
    for (int k = 0; k < NumPe; k++) begin
      elem = c_i[k*OutDataWidth +: OutDataWidth];
      if ($signed(elem) > $signed(SatMax)) begin
        capt_data[k*OutDataWidth +: OutDataWidth] = SatMax;
      end else if ($signed(elem) < $signed(SatMin)) begin
        capt_data[k*OutDataWidth +: OutDataWidth] = SatMin;
      end else begin
        capt_data[k*OutDataWidth +: OutDataWidth] = elem;
      end
    end
  end
`else
  assign capt_data = c_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      buf_q      <= '0;
      base_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      buf_q      <= buf_d;
      base_q     <= base_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    buf_d      = buf_q;
    base_d     = base_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture_i) begin
          buf_d      = capt_data;
          base_d     = base_addr_i;
          beat_cnt_d = '0;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready_i) begin
          if (beat_cnt_q == LastBeat) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Data and address are forced to zero outside DRAIN so idle outputs match reset.
  always_comb begin
    out_data_o = '0;
    out_addr_o = '0;
    if (state_q == DRAIN) begin
      out_addr_o = base_q + AddrWidth'(beat_cnt_q);
      for (int j = 0; j < NumLanes; j++) begin
        out_data_o[j*OutDataWidth +: OutDataWidth] =
          buf_q[(int'(beat_cnt_q)*NumLanes + j)*OutDataWidth +: OutDataWidth];
      end
    end
  end

  assign capture_ready_o = (state_q == IDLE);
  assign out_valid_o     = (state_q == DRAIN);
  assign busy_o          = (state_q == DRAIN);
  assign out_last_o      = (state_q == DRAIN) && (beat_cnt_q == LastBeat);
  assign done_o          = done_q;

endmodule

// File: tb/tb_gemm_output_drain.sv
// Self-checking bench for gemm_output_drain: randomized snapshots checked beat by beat
// against an array-based model of the expected stream.
module tb_gemm_output_drain;
  localparam int W     = 32;
  localparam int NP    = 16;
  localparam int NL    = 4;
  localparam int AW    = 16;
  localparam int SW    = 16;
  localparam int BEATS = NP / NL;
  localparam int GW    = 5 + AW + NL*W;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NP*W-1:0]   c_i;
  logic              capture_i;
  logic              capture_ready_o;
  logic [AW-1:0]     base_addr_i;
  logic [NL*W-1:0]   out_data_o;
  logic [AW-1:0]     out_addr_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic              out_last_o;
  logic              busy_o;
  logic              done_o;

  gemm_output_drain #(
    .OutDataWidth(W), .NumPe(NP), .NumLanes(NL), .AddrWidth(AW), .SatWidth(SW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .c_i(c_i), .capture_i(capture_i),
    .capture_ready_o(capture_ready_o), .base_addr_i(base_addr_i),
    .out_data_o(out_data_o), .out_addr_o(out_addr_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_last_o(out_last_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int            n_checks = 0;
  int            n_pass   = 0;
  int            stim[NP];
  int            snap[NP];
  logic [AW-1:0] sbase;

  function automatic int sat_model(input int v);
`ifdef DRAIN_SATURATE_EN
    int hi = (1 << (SW-1)) - 1;
    int lo = -(1 << (SW-1));
    if (v > hi) return hi;
    if (v < lo) return lo;
`endif
    return v;
  endfunction

  function automatic logic [GW-1:0] observed();
    return {out_valid_o, out_last_o, busy_o, capture_ready_o, done_o, out_addr_o, out_data_o};
  endfunction

  // Called at a negedge in IDLE; returns at the negedge after the accepting edge.
  task automatic do_capture(input logic [AW-1:0] base);
    for (int k = 0; k < NP; k++) c_i[k*W +: W] = stim[k];
    base_addr_i = base;
    capture_i   = 1'b1;
    for (int k = 0; k < NP; k++) snap[k] = sat_model(stim[k]);
    sbase = base;
    @(negedge clk_i);
    capture_i = 1'b0;
  endtask

  // mode 0: always ready; mode 1: ready low 3 cycles during beat 1; mode 2: random ready.
  task automatic drain(input int mode, input bit spam, input bit chain);
    int beat  = 0;
    int cyc   = 0;
    int stall = 0;
    logic ready;
    logic [NL*W-1:0] ed;
    logic [AW-1:0]   ea;
    logic [GW-1:0]   exp_v, got;
    while (beat < BEATS && cyc < 64) begin
      case (mode)
        0: ready = 1'b1;
        1: begin
          ready = !(beat == 1 && stall < 3);
          if (!ready) stall++;
        end
        default: ready = 1'($urandom_range(0, 1));
      endcase
      out_ready_i = ready;
      if (spam) begin
        for (int k = 0; k < NP; k++) c_i[k*W +: W] = $urandom;
        base_addr_i = 16'($urandom);
        capture_i   = 1'b1;
      end
      for (int j = 0; j < NL; j++) ed[j*W +: W] = snap[beat*NL + j];
      ea    = sbase + AW'(beat);
      exp_v = {1'b1, (beat == BEATS-1), 1'b1, 1'b0, 1'b0, ea, ed};
      got   = observed();
      n_checks++;
      if (got !== exp_v) $display("FAIL drain_beat%0d cyc%0d got=%h exp=%h", beat, cyc, got, exp_v);
      else n_pass++;
      if (ready) beat++;
      cyc++;
      @(negedge clk_i);
    end
    capture_i = 1'b0;
    n_checks++;
    if (beat != BEATS) $display("FAIL drain_timeout beats=%0d exp=%0d", beat, BEATS);
    else n_pass++;
    if (mode != 2) begin
      n_checks++;
      if (cyc != BEATS + (mode == 1 ? 3 : 0))
        $display("FAIL drain_cycles got=%0d exp=%0d", cyc, BEATS + (mode == 1 ? 3 : 0));
      else n_pass++;
    end
    n_checks++;
    if ({out_valid_o, busy_o, capture_ready_o, done_o, out_last_o} !== 5'b00110)
      $display("FAIL done_cycle got=%b exp=00110",
               {out_valid_o, busy_o, capture_ready_o, done_o, out_last_o});
    else n_pass++;
    if (!chain) begin
      @(negedge clk_i);
      n_checks++;
      if ({out_valid_o, capture_ready_o, done_o} !== 3'b010)
        $display("FAIL done_single got=%b exp=010", {out_valid_o, capture_ready_o, done_o});
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; capture_i = 1'b0; out_ready_i = 1'b0; c_i = '0; base_addr_i = '0;
    repeat (2) @(negedge clk_i);
    n_checks++;
    if (observed() !== {5'b00010, {AW{1'b0}}, {NL*W{1'b0}}})
      $display("FAIL reset_state got=%h", observed());
    else n_pass++;
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_basic();
    for (int k = 0; k < NP; k++) stim[k] = 3*k - 20;
    out_ready_i = 1'b1;
    do_capture(16'h0100);
    drain(0, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    for (int k = 0; k < NP; k++) stim[k] = 3*k - 20;
    do_capture(16'h0100);
    drain(1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < NP; k++) stim[k] = int'($urandom);
    do_capture(16'($urandom));
    drain(2, 1'b1, 1'b1);
    for (int k = 0; k < NP; k++) stim[k] = int'($urandom);
    do_capture(16'($urandom));
    drain(0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    for (int k = 0; k < NP; k++) stim[k] = int'($urandom);
    do_capture(16'hFFFE);
    drain(0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_drain();
    for (int k = 0; k < NP; k++) stim[k] = int'($urandom);
    out_ready_i = 1'b1;
    do_capture(16'h0200);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (observed() !== {5'b00010, {AW{1'b0}}, {NL*W{1'b0}}})
      $display("FAIL mid_reset got=%h", observed());
    else n_pass++;
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      n_checks++;
      if ({out_valid_o, busy_o, done_o, capture_ready_o} !== 4'b0001)
        $display("FAIL post_reset_idle cyc%0d got=%b exp=0001", i,
                 {out_valid_o, busy_o, done_o, capture_ready_o});
      else n_pass++;
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < NP; k++) stim[k] = int'($urandom);
    stim[0] = 100000; stim[1] = -70000; stim[2] = 1234; stim[3] = -32768;
    do_capture(16'h0040);
    drain(0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < NP; k++) stim[k] = int'($urandom);
      do_capture(16'($urandom));
      drain(2, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_wrap();
    test_reset_mid_drain();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
